// File: rtl/tile_vram_responder_if.sv
// Avalon-MM read port plus loader write port shared by the tile engine and the VRAM loader.
interface tile_vram_responder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              avs_s0_read;
    logic [31:0]       avs_s0_address;
    logic [31:0]       avs_s0_readdata;
    logic              avs_s0_waitrequest;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_byteenable;

    modport master (
        output avs_s0_read, avs_s0_address, wr_en, wr_addr, wr_data, wr_byteenable,
        input  avs_s0_readdata, avs_s0_waitrequest
    );

    modport slave (
        input  avs_s0_read, avs_s0_address, wr_en, wr_addr, wr_data, wr_byteenable,
        output avs_s0_readdata, avs_s0_waitrequest
    );
endinterface

// File: rtl/tile_vram_responder.sv
// Tile/pattern RAM with a waitrequest-stalled Avalon-MM read slave and a byte-enabled loader write port.
// Read data is captured at the accept edge, then released after RD_LATENCY cycles.
module tile_vram_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                 clk_50M,
    input  logic                 rst,
    tile_vram_responder_if.slave s_if
);
    localparam int unsigned PIPE_W = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    logic              r_waitrequest;
    logic [31:0]       r_readdata;
    logic [31:0]       r_capt;
    logic [PIPE_W-1:0] r_pipe;

    logic [ADDR_W-1:0] w_idx;
    logic              w_oob;
    logic [31:0]       w_word;
    logic [1:0]        w_unused_addr;

    assign w_idx         = s_if.avs_s0_address[ADDR_W+1:2];
    assign w_oob         = |s_if.avs_s0_address[31:ADDR_W+2];
    assign w_word        = w_oob ? 32'h0 : r_mem[w_idx];
    assign w_unused_addr = s_if.avs_s0_address[1:0];

    assign s_if.avs_s0_readdata    = r_readdata;
    assign s_if.avs_s0_waitrequest = r_waitrequest;

    // Loader writes: byte-granular, never stalled, independent of the read FSM.
    always_ff @(posedge clk_50M) begin
        if (s_if.wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (s_if.wr_byteenable[i]) begin
                    r_mem[s_if.wr_addr][8*i +: 8] <= s_if.wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read FSM; r_pipe carries a single token through RD_LATENCY-1 WAIT cycles.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_waitrequest <= 1'b1;
            r_readdata    <= 32'h0;
            r_capt        <= 32'h0;
            r_pipe        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_waitrequest <= 1'b1;
                    if (s_if.avs_s0_read) begin
                        if (RD_LATENCY > 1) begin
                            r_capt  <= w_word;
                            r_pipe  <= PIPE_W'(1);
                            r_state <= ST_WAIT;
                        end else begin
                            r_readdata    <= w_word;
                            r_waitrequest <= 1'b0;
                            r_state       <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    // A master dropping read mid-stall gets no response.
                    if (!s_if.avs_s0_read) begin
                        r_pipe  <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_pipe[PIPE_W-1]) begin
                        r_pipe        <= '0;
                        r_readdata    <= r_capt;
                        r_waitrequest <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_pipe <= r_pipe << 1;
                    end
                end
                ST_RESP: begin
                    r_waitrequest <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_waitrequest <= 1'b1;
                    r_pipe        <= '0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_vram_responder.sv
// Directed bench for tile_vram_responder: a scoreboard queue holds the word expected at each accept.
module tb_tile_vram_responder;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned RD_LATENCY = 2;

    logic clk_50M;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic [31:0] mdl [DEPTH];
    logic [31:0] sb [$];

    tile_vram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    tile_vram_responder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_50M(clk_50M),
        .rst    (rst),
        .s_if   (bus.slave)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en         = 1'b1;
        bus.wr_addr       = a;
        bus.wr_data       = d;
        bus.wr_byteenable = be;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
        end
        step();
        bus.wr_en = 1'b0;
    endtask

    // Drives one read; optional same-cycle write to the same word; checks latency and data.
    task automatic rd(input logic [31:0] addr, input bit keep, input bit wr_same,
                      input logic [31:0] wd, input string tag, output int resp_cyc);
        logic [31:0] exp;
        int          lat;
        bus.avs_s0_address = addr;
        bus.avs_s0_read    = 1'b1;
        sb.push_back((addr[31:12] != 20'h0) ? 32'h0 : mdl[addr[11:2]]);
        if (wr_same) begin
            bus.wr_en         = 1'b1;
            bus.wr_addr       = addr[11:2];
            bus.wr_data       = wd;
            bus.wr_byteenable = 4'hF;
            mdl[addr[11:2]]   = wd;
        end
        lat = 0;
        while (bus.avs_s0_waitrequest !== 1'b0 && lat < 16) begin
            step();
            bus.wr_en = 1'b0;
            lat++;
        end
        bus.wr_en = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(RD_LATENCY));
        exp = sb.pop_front();
        chk({tag, "_data"}, bus.avs_s0_readdata, exp);
        resp_cyc = cyc;
        step();
        if (!keep) bus.avs_s0_read = 1'b0;
        chk({tag, "_wr_back"}, 32'(bus.avs_s0_waitrequest), 32'h1);
    endtask

    initial begin
        int r0;
        int r1;
        checks             = 0;
        errors             = 0;
        cyc                = 0;
        rst                = 1'b1;
        bus.avs_s0_read    = 1'b0;
        bus.avs_s0_address = 32'h0;
        bus.wr_en          = 1'b0;
        bus.wr_addr        = '0;
        bus.wr_data        = 32'h0;
        bus.wr_byteenable  = 4'h0;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;

        repeat (2) step();
        chk("rst_wait", 32'(bus.avs_s0_waitrequest), 32'h1);
        chk("rst_data", bus.avs_s0_readdata, 32'h0);
        rst = 1'b0;
        step();

        // Basic read at word 5.
        do_write(10'd5, 32'hA5A5_1234, 4'hF);
        rd(32'h0000_0014, 1'b0, 1'b0, 32'h0, "basic", r0);

        // Back-to-back with read held high.
        do_write(10'd0, 32'h0BAD_F00D, 4'hF);
        do_write(10'd1, 32'h1357_9BDF, 4'hF);
        rd(32'h0000_0000, 1'b1, 1'b0, 32'h0, "b2b0", r0);
        rd(32'h0000_0004, 1'b0, 1'b0, 32'h0, "b2b1", r1);
        chk("b2b_gap", 32'(r1 - r0), 32'(RD_LATENCY + 1));

        // Partial byte-enable write.
        do_write(10'd7, 32'h1111_1111, 4'hF);
        do_write(10'd7, 32'hFFFF_FFFF, 4'b0101);
        rd(32'h0000_001C, 1'b0, 1'b0, 32'h0, "byteen", r0);

        // Write in the accept cycle is not visible; the following read sees it.
        do_write(10'd9, 32'h9999_9999, 4'hF);
        rd(32'h0000_0024, 1'b0, 1'b1, 32'hCAFE_0000, "rdw_old", r0);
        rd(32'h0000_0024, 1'b0, 1'b0, 32'h0, "rdw_new", r0);

        // Out-of-range address reads zero at normal latency.
        rd(32'h0000_1000, 1'b0, 1'b0, 32'h0, "oob", r0);

        // Read dropped during WAIT: no response.
        bus.avs_s0_address = 32'h0000_0014;
        bus.avs_s0_read    = 1'b1;
        step();
        bus.avs_s0_read = 1'b0;
        chk("drop_w1", 32'(bus.avs_s0_waitrequest), 32'h1);
        step();
        chk("drop_w2", 32'(bus.avs_s0_waitrequest), 32'h1);
        step();
        chk("drop_w3", 32'(bus.avs_s0_waitrequest), 32'h1);
        rd(32'h0000_0014, 1'b0, 1'b0, 32'h0, "post_drop", r0);

        // Reset during WAIT aborts the read and clears readdata.
        bus.avs_s0_address = 32'h0000_001C;
        bus.avs_s0_read    = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("rstw_wait", 32'(bus.avs_s0_waitrequest), 32'h1);
        chk("rstw_data", bus.avs_s0_readdata, 32'h0);
        rst             = 1'b0;
        bus.avs_s0_read = 1'b0;
        step();
        chk("rstw_idle", 32'(bus.avs_s0_waitrequest), 32'h1);
        rd(32'h0000_001C, 1'b0, 1'b0, 32'h0, "post_rst", r0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
